izh_neuron_array: RTL and testbench

Time-multiplexed array of `N_NEURONS` Izhikevich neurons sharing one fixed-point update datapath. This is the parametrised successor to the single-neuron Tiny Tapeout core: it is generalised in neuron count and word width. It adds per-neuron state storage, a start/done handshake and a packed spike vector. It sits between the stimulus/config front end and the spike-output encoder.

---
 rtl/izh_pkg.sv | 49 ++++
 rtl/izh_step.sv | 55 +++++
 rtl/izh_neuron_array.sv | 167 ++++++++++++++++
 tb/tb_izh_neuron_array.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared constants, FSM encoding and saturation helper for the Izhikevich array.
// Q-format constants are functions of the fractional width FRAC.
package izh_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_WB,
        S_FIN
    } state_t;

    localparam int REFRAC_CYC = 2;

    function automatic int vrest(input int frac);
        return -(65 <<< frac);
    endfunction

    function automatic int urest(input int frac);
        return -(13 <<< frac);
    endfunction

    function automatic int vpeak(input int frac);
        return 30 <<< frac;
    endfunction

    // round(0.04 * 2^frac)
    function automatic int k004(input int frac);
        return (4 * (1 <<< frac) + 50) / 100;
    endfunction

    function automatic int k140(input int frac);
        return 140 <<< frac;
    endfunction

    function automatic logic signed [63:0] sat_w(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/izh_step.sv
// Combinational Izhikevich update for one neuron: Euler step, saturation
// and spike/reset handling.
module izh_step
    import izh_pkg::*;
#(
    parameter int W        = 16,
    parameter int FRAC     = 8,
    parameter int DT_SHIFT = 0
) (
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] u,
    input  logic signed [W-1:0] i,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    output logic signed [W-1:0] v_nxt,
    output logic signed [W-1:0] u_nxt,
    output logic                spike
);

    localparam int IW = 2 * W + 4;

    localparam logic signed [IW-1:0] K004 = IW'(k004(FRAC));
    localparam logic signed [IW-1:0] K140 = IW'(k140(FRAC));
    localparam logic signed [W-1:0]  VPK  = W'(vpeak(FRAC));

    logic signed [IW-1:0] ve, ue, ie, ae, be;
    logic signed [IW-1:0] sq, bv, dv, du, vn, un;
    logic signed [W-1:0]  v_sat, u_sat, u_spk;

    always_comb begin
        ve = {{(IW-W){v[W-1]}}, v};
        ue = {{(IW-W){u[W-1]}}, u};
        ie = {{(IW-W){i[W-1]}}, i};
        ae = {{(IW-W){a[W-1]}}, a};
        be = {{(IW-W){b[W-1]}}, b};

        sq = (ve * ve) >>> FRAC;
        dv = ((sq * K004) >>> FRAC) + ve + (ve <<< 2) + K140 - ue + ie;
        bv = (be * ve) >>> FRAC;
        du = (ae * (bv - ue)) >>> FRAC;
        vn = ve + (dv >>> DT_SHIFT);
        un = ue + (du >>> DT_SHIFT);

        v_sat = W'(sat_w(64'(vn), W));
        u_sat = W'(sat_w(64'(un), W));
        u_spk = W'(sat_w(64'(u_sat) + 64'(d), W));

        spike = (v_sat >= VPK);
        v_nxt = spike ? c : v_sat;
        u_nxt = spike ? u_spk : u_sat;
    end

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: FSM, per-neuron state and latches.
// Define IZH_REFRACTORY_EN to add a per-neuron refractory counter.
module izh_neuron_array
    import izh_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int W         = 16,
    parameter int FRAC      = 8,
    parameter int DT_SHIFT  = 0,
    localparam int SW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_NEURONS*W-1:0] i_in,
    input  logic [W-1:0]           a_in,
    input  logic [W-1:0]           b_in,
    input  logic [W-1:0]           c_in,
    input  logic [W-1:0]           d_in,
    output logic                   busy,
    output logic                   done,
    output logic [N_NEURONS-1:0]   spikes,
    output logic [W-1:0]           v_mon,
    input  logic [SW-1:0]          mon_sel
);

    localparam logic signed [W-1:0] V0 = W'(vrest(FRAC));
    localparam logic signed [W-1:0] U0 = W'(urest(FRAC));

    state_t state, state_nxt;

    logic [SW-1:0]          idx;
    logic                   last;
    logic signed [W-1:0]    v_mem [N_NEURONS];
    logic signed [W-1:0]    u_mem [N_NEURONS];
    logic [N_NEURONS*W-1:0] i_lat;
    logic signed [W-1:0]    a_lat, b_lat, c_lat, d_lat;
    logic signed [W-1:0]    v_w, u_w, i_w;
    logic signed [W-1:0]    v_c, u_c;
    logic                   spk_c;
    logic signed [W-1:0]    v_s, u_s;
    logic                   spk_s;

    assign last = (idx == SW'(N_NEURONS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = S_CALC;
            S_CALC: state_nxt = S_WB;
            S_WB:   state_nxt = last ? S_FIN : S_LOAD;
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    izh_step #(
        .W        (W),
        .FRAC     (FRAC),
        .DT_SHIFT (DT_SHIFT)
    ) u_step (
        .v     (v_w),
        .u     (u_w),
        .i     (i_w),
        .a     (a_lat),
        .b     (b_lat),
        .c     (c_lat),
        .d     (d_lat),
        .v_nxt (v_s),
        .u_nxt (u_s),
        .spike (spk_s)
    );

    // Input latches and working registers carry no architectural reset
    // dependency beyond a clean start value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            i_lat <= '0;
            a_lat <= '0;
            b_lat <= '0;
            c_lat <= '0;
            d_lat <= '0;
            v_c   <= '0;
            u_c   <= '0;
            spk_c <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                idx   <= '0;
                i_lat <= i_in;
                a_lat <= a_in;
                b_lat <= b_in;
                c_lat <= c_in;
                d_lat <= d_in;
            end
            if (state == S_CALC) begin
                v_c   <= v_s;
                u_c   <= u_s;
                spk_c <= spk_s;
            end
            if (state == S_WB && !last) idx <= idx + SW'(1);
        end
    end

`ifdef IZH_REFRACTORY_EN
    logic [3:0] rcnt [N_NEURONS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) rcnt[k] <= 4'd0;
        end else if (state == S_WB) begin
            if (spk_c)               rcnt[idx] <= 4'(REFRAC_CYC);
            else if (rcnt[idx] != 0) rcnt[idx] <= rcnt[idx] - 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_w <= '0;
            u_w <= '0;
            i_w <= '0;
        end else if (state == S_LOAD) begin
            v_w <= v_mem[idx];
            u_w <= u_mem[idx];
`ifdef IZH_REFRACTORY_EN
            i_w <= (rcnt[idx] != 4'd0) ? '0 : i_lat[int'(idx)*W +: W];
`else
            i_w <= i_lat[int'(idx)*W +: W];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k] <= V0;
                u_mem[k] <= U0;
            end
            spikes <= '0;
        end else if (state == S_WB) begin
            v_mem[idx]  <= v_c;
            u_mem[idx]  <= u_c;
            spikes[idx] <= spk_c;
        end
    end

    always_comb begin
        v_mon = '0;
        if (int'(mon_sel) < N_NEURONS) v_mon = v_mem[mon_sel];
    end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Self-checking bench for izh_neuron_array against a plain-arithmetic model.
// Honours IZH_REFRACTORY_EN in the model when the macro is defined.
module tb_izh_neuron_array;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int DT   = 0;
    localparam int SW   = 2;

    // Real-valued model constants scaled by 2^8: -65, -13, 30, 0.04, 140
    localparam longint M_VREST = -16640;
    localparam longint M_UREST = -3328;
    localparam longint M_VPEAK = 7680;
    localparam longint M_K004  = 10;
    localparam longint M_K140  = 35840;
    localparam int     STEP_CYC = 3 * N + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [N*W-1:0] i_in = '0;
    logic [W-1:0]   a_in = '0, b_in = '0, c_in = '0, d_in = '0;
    logic           busy, done;
    logic [N-1:0]   spikes;
    logic [W-1:0]   v_mon;
    logic [SW-1:0]  mon_sel = '0;

    int ntot = 0, npass = 0, nfail = 0;

    longint mv [N];
    longint mu [N];
    int     mref [N];
    logic [N-1:0] mspk;
    longint lat_i [N];
    longint la, lb, lc, ld;
    int     step_no = 0;
    int     last_spk [N];

    always #5 clk = ~clk;

    izh_neuron_array #(
        .N_NEURONS (N),
        .W         (W),
        .FRAC      (FRAC),
        .DT_SHIFT  (DT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .i_in    (i_in),
        .a_in    (a_in),
        .b_in    (b_in),
        .c_in    (c_in),
        .d_in    (d_in),
        .busy    (busy),
        .done    (done),
        .spikes  (spikes),
        .v_mon   (v_mon),
        .mon_sel (mon_sel)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic longint q(input real r);
        return longint'($rtoi(r * 256.0 + ((r < 0.0) ? -0.5 : 0.5)));
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = M_VREST;
            mu[n] = M_UREST;
            mref[n] = 0;
        end
        mspk = '0;
    endtask

    task automatic model_latch();
        for (int n = 0; n < N; n++) lat_i[n] = longint'($signed(i_in[n*W +: W]));
        la = longint'($signed(a_in));
        lb = longint'($signed(b_in));
        lc = longint'($signed(c_in));
        ld = longint'($signed(d_in));
    endtask

    task automatic model_step();
        longint v, u, cur, sq, dv, du, vn, un;
        for (int n = 0; n < N; n++) begin
            v = mv[n];
            u = mu[n];
            cur = lat_i[n];
`ifdef IZH_REFRACTORY_EN
            if (mref[n] > 0) cur = 0;
`endif
            sq = (v * v) >>> FRAC;
            dv = ((sq * M_K004) >>> FRAC) + 5 * v + M_K140 - u + cur;
            du = (la * (((lb * v) >>> FRAC) - u)) >>> FRAC;
            vn = sat16(v + (dv >>> DT));
            un = sat16(u + (du >>> DT));
            if (vn >= M_VPEAK) begin
                mv[n] = lc;
                mu[n] = sat16(un + ld);
                mspk[n] = 1'b1;
                mref[n] = 2;
            end else begin
                mv[n] = vn;
                mu[n] = un;
                mspk[n] = 1'b0;
                if (mref[n] > 0) mref[n]--;
            end
        end
    endtask

    task automatic check_all_v(input string tag);
        for (int n = 0; n < N; n++) begin
            mon_sel = SW'(n);
            #1;
            chk(tag, longint'($signed(v_mon)), mv[n]);
        end
    endtask

    task automatic scramble_inputs();
        i_in = {$urandom, $urandom};
        a_in = W'($urandom);
        b_in = W'($urandom);
        c_in = W'($urandom);
        d_in = W'($urandom);
    endtask

    // One full step: start pulse, optional second start at cycle 'glitch',
    // optional input scrambling mid-step, then done timing and state checks.
    task automatic run_step(input int glitch, input bit scr);
        int got, ndone;
        @(posedge clk);
        #1;
        start = 1'b1;
        model_latch();
        model_step();
        step_no++;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 0;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_c1", busy, 1);
            if (done) begin
                if (got == 0) got = k;
                ndone++;
            end
            if (k == 2 && scr) scramble_inputs();
            start = (k == glitch);
        end
        start = 1'b0;
        chk("done_cycle", got, STEP_CYC);
        chk("done_count", ndone, 1);
        chk("busy_idle", busy, 0);
        chk("spikes", spikes, mspk);
        check_all_v("v_mon");
`ifdef IZH_REFRACTORY_EN
        for (int n = 0; n < N; n++) begin
            if (spikes[n]) begin
                chk("refrac_gap", (step_no - last_spk[n] >= 3), 1);
                last_spk[n] = step_no;
            end
        end
`endif
    endtask

    task automatic set_rs(input longint i0, input longint i1,
                          input longint i2, input longint i3);
        i_in[0*W +: W] = W'(i0);
        i_in[1*W +: W] = W'(i1);
        i_in[2*W +: W] = W'(i2);
        i_in[3*W +: W] = W'(i3);
        a_in = W'(q(0.02));
        b_in = W'(q(0.2));
        c_in = W'(q(-65.0));
        d_in = W'(q(8.0));
    endtask

    initial begin
        int ndone;
        logic [N-1:0] seen;
        for (int n = 0; n < N; n++) last_spk[n] = -100;

        // reset state
        rst = 1'b1;
        model_reset();
        #12;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spikes", spikes, 0);
        for (int n = 0; n < N; n++) begin
            mon_sel = SW'(n);
            #1;
            chk("rst_v_hex", v_mon, 16'hBF00);
        end

        // quiescent RS neuron, inputs scrambled mid-step
        set_rs(0, 0, 0, 0);
        run_step(0, 1'b1);

        // drive only neuron 2; second start at cycle 5 must be ignored
        seen = '0;
        for (int s = 0; s < 10; s++) begin
            set_rs(0, 0, q(10.0), 0);
            run_step((s == 0) ? 5 : 0, 1'b0);
            seen |= spikes;
            if (spikes[2]) begin
                mon_sel = 2'd2;
                #1;
                chk("spike_v_eq_c", v_mon, 16'hBF00);
            end
        end
        chk("only_n2_spikes", seen & 4'b1011, 0);
        chk("n2_spiked", seen[2], 1);

        // reset asserted mid-step
        set_rs(q(5.0), q(5.0), q(5.0), q(5.0));
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (k == 6) begin
                rst = 1'b1;
                #1;
                chk("midrst_busy", busy, 0);
                chk("midrst_spikes", spikes, 0);
            end
            if (k == 7) rst = 1'b0;
        end
        model_reset();
        for (int n = 0; n < N; n++) last_spk[n] = -100;
        chk("midrst_no_done", ndone, 0);
        check_all_v("midrst_v");

        set_rs(q(5.0), q(5.0), q(5.0), q(5.0));
        run_step(0, 1'b0);

        // random currents and parameters near the RS regime
        for (int s = 0; s < 10; s++) begin
            set_rs(0, 0, 0, 0);
            for (int n = 0; n < N; n++)
                i_in[n*W +: W] = W'(int'($urandom_range(6400)) - 1280);
            a_in = W'(int'($urandom_range(30)));
            d_in = W'(int'($urandom_range(3072)));
            run_step(0, 1'b1);
        end

        // strong drive to exercise repeated spiking
        for (int s = 0; s < 15; s++) begin
            set_rs(q(20.0), q(20.0), q(20.0), q(20.0));
            run_step(0, 1'b0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
